// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - lsu_state_e : FSM state encoding (IDLE, REQ, DONE)
//   - LSU_ADDR_W / LSU_DATA_W : default address and data widths
//   - LSU_TIMEOUT : default number of REQ cycles allowed before an access errors out
//   - LSU_CNT_W : width of the timeout counter
package lsu_pkg;

  localparam int LSU_ADDR_W  = 32;
  localparam int LSU_DATA_W  = 32;
  localparam int LSU_TIMEOUT = 15;
  localparam int LSU_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts cycles spent waiting for the memory acknowledge.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   clear     : synchronously zero the count (has priority over enable)
//   enable    : count this cycle
//   expired   : high in the enabled cycle that brings the count to TIMEOUT
// The count holds the number of enabled cycles already completed, so the
// cycle being counted right now is included by comparing count+1.
module lsu_timeout_counter
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [LSU_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != {LSU_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable &&
                   (({1'b0, cnt_q} + (LSU_CNT_W+1)'(1)) >= (LSU_CNT_W+1)'(TIMEOUT));

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage between execute and writeback.
// Latches the effective address, store data and direction of a memory
// instruction, runs a req/ack handshake with a variable-latency data memory,
// stalls the core while the access is pending and presents the result for
// one cycle with done_o.
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   valid_i, memread_i, memwrite_i: instruction valid and memory controls
//   addr_i, wdata_i               : effective address and store data
//   stall_o                       : hold PC/regfile write while access pending
//   done_o, err_o                 : one-cycle completion / failure pulse
//   rdata_o                       : load result (0 for stores and errors)
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i
//                                 : data memory handshake
//   dbg_state                     : current FSM state
// Optional macro: LSU_ALIGN_CHECK_EN -- misaligned accesses complete
// immediately with an error instead of being issued with the low address
// bits cleared.
//
// Memory handshake: mem_req_o rises on entry to REQ and stays high with
// mem_addr_o/mem_we_o/mem_wdata_o stable until the cycle in which mem_ack_i
// is sampled high; mem_rdata_i is taken in that same cycle. mem_ack_i is
// ignored in every other state.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int DATA_W  = LSU_DATA_W,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              start;
  logic              expired;

  assign start = valid_i && (memread_i || memwrite_i);

  lsu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != REQ),
    .enable  (state_q == REQ),
    .expired (expired)
  );

  // The core must not advance in the cycle a memory instruction is first
  // seen, so stall is combinational on start in IDLE.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:    stall_o = start;
      REQ:     stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_req_o <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= memwrite_i;  // a store wins if both controls are set
`ifdef LSU_ALIGN_CHECK_EN
            if (addr_i[1:0] != 2'b00) begin
              state_q <= DONE;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else begin
              state_q   <= REQ;
              mem_req_o <= 1'b1;
            end
`else
            state_q   <= REQ;
            mem_req_o <= 1'b1;
`endif
          end
        end
        REQ: begin
          // An ack in the expiry cycle still completes the access normally.
          if (mem_ack_i) begin
            state_q   <= DONE;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            rdata_o   <= we_q ? '0 : mem_rdata_i;
          end else if (expired) begin
            state_q   <= DONE;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            rdata_o   <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign dbg_state   = state_q;

`ifdef LSU_ALIGN_CHECK_EN
  assign mem_addr_o = addr_q;
`else
  // Word-addressed memory: clear the byte offset instead of faulting.
  assign mem_addr_o = addr_q & ~ADDR_W'(3);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int W       = DATA_W + 1;  // {err, rdata}

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              memread = 1'b0;
  logic              memwrite = 1'b0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              stall, done, err, mem_req, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  lsu_state_e        dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .memread_i  (memread),
    .memwrite_i (memwrite),
    .stall_o    (stall),
    .done_o     (done),
    .err_o      (err),
    .rdata_o    (rdata),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      exp;
  int                checks = 0;
  int                errors = 0;

  int                done_cyc, stall_cnt, req_cnt;
  logic [ADDR_W-1:0] seen_addr;
  logic [DATA_W-1:0] seen_wdata, seen_rdata;
  logic              seen_we, seen_err, seen_stall_done, seen_req_done;

  // ---------------- driver tasks ----------------
  // Called at posedge+1: presents a memory instruction for cycle 0.
  task automatic start_access(input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    valid = 1'b1; memread = rd; memwrite = wr; addr = a; wdata = d;
  endtask

  // Runs cycles 0..max_cyc, acking in cycle ack_at (-1 = never), and records
  // what the DUT showed. Returns one cycle after done with inputs released.
  task automatic run_until_done(input int ack_at, input logic [DATA_W-1:0] ack_data,
                                input int max_cyc);
    done_cyc = -1; stall_cnt = 0; req_cnt = 0;
    seen_addr = 'x; seen_wdata = 'x; seen_we = 1'bx;
    seen_rdata = 'x; seen_err = 1'bx; seen_stall_done = 1'bx; seen_req_done = 1'bx;
    for (int c = 0; c <= max_cyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? ack_data : DATA_W'($urandom);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++; seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
      end
      if (done) begin
        done_cyc = c; seen_err = err; seen_rdata = rdata;
        seen_stall_done = stall; seen_req_done = mem_req;
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_load();
    start_access(1'b1, 1'b0, 32'h10, 32'h0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    run_until_done(2, 32'hDEADBEEF, 40);
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL load_done_cycle: got %0d expected 3", done_cyc); end
    checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cnt); end
    checks++; if (req_cnt !== 2) begin errors++; $display("FAIL load_req_cycles: got %0d expected 2", req_cnt); end
    checks++; if (seen_addr !== 32'h10) begin errors++; $display("FAIL load_mem_addr: got %h expected 10", seen_addr); end
    checks++; if (seen_we !== 1'b0) begin errors++; $display("FAIL load_mem_we: got %b expected 0", seen_we); end
    checks++; if (seen_stall_done !== 1'b0) begin errors++; $display("FAIL load_stall_in_done: got %b expected 0", seen_stall_done); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL load_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
    @(negedge clk);
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata_hold: got %h expected deadbeef", rdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got %b expected 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    // Both controls set: the store must win.
    start_access(1'b1, 1'b1, 32'h8, 32'h5);
    exp_q.push_back({1'b0, 32'h0});
    run_until_done(1, 32'h77777777, 40);
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL store_done_cycle: got %0d expected 2", done_cyc); end
    checks++; if (seen_we !== 1'b1) begin errors++; $display("FAIL store_mem_we: got %b expected 1", seen_we); end
    checks++; if (seen_wdata !== 32'h5) begin errors++; $display("FAIL store_mem_wdata: got %h expected 5", seen_wdata); end
    checks++; if (seen_addr !== 32'h8) begin errors++; $display("FAIL store_mem_addr: got %h expected 8", seen_addr); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL store_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
  endtask

  task automatic test_ack_at_timeout();
    start_access(1'b1, 1'b0, 32'h30, 32'h0);
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    run_until_done(TIMEOUT, 32'hCAFEF00D, 40);
    checks++; if (done_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL ack_at_timeout_done_cycle: got %0d expected %0d", done_cyc, TIMEOUT + 1); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL ack_at_timeout_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
  endtask

  task automatic test_timeout();
    start_access(1'b1, 1'b0, 32'h20, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    run_until_done(-1, 32'h0, 40);
    checks++; if (done_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_done_cycle: got %0d expected %0d", done_cyc, TIMEOUT + 1); end
    checks++; if (req_cnt !== TIMEOUT) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cnt, TIMEOUT); end
    checks++; if (seen_req_done !== 1'b0) begin errors++; $display("FAIL timeout_req_in_done: got %b expected 0", seen_req_done); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL timeout_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
  endtask

  task automatic test_back_to_back();
    logic              wr;
    int                lat;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, rd_data;
    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 8);
      a = ADDR_W'($urandom_range(0, 1023)) << 2;
      d = DATA_W'($urandom);
      rd_data = DATA_W'($urandom);
      start_access(~wr | 1'($urandom_range(0, 1)), wr, a, d);
      exp_q.push_back({1'b0, (wr ? 32'h0 : rd_data)});
      run_until_done(lat, rd_data, 40);
      checks++; if (done_cyc !== lat + 1) begin errors++; $display("FAIL b2b_done_cycle[%0d]: got %0d expected %0d", i, done_cyc, lat + 1); end
      checks++; if (seen_addr !== a) begin errors++; $display("FAIL b2b_mem_addr[%0d]: got %h expected %h", i, seen_addr, a); end
      checks++; if (seen_we !== wr) begin errors++; $display("FAIL b2b_mem_we[%0d]: got %b expected %b", i, seen_we, wr); end
      if (wr) begin
        checks++; if (seen_wdata !== d) begin errors++; $display("FAIL b2b_mem_wdata[%0d]: got %h expected %h", i, seen_wdata, d); end
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, {seen_err, seen_rdata}, exp); end
    end
  endtask

  task automatic test_reset_in_flight();
    // Leave a nonzero rdata behind so the reset clear is observable.
    start_access(1'b1, 1'b0, 32'h44, 32'h0);
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    run_until_done(1, 32'hA5A5A5A5, 40);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL rst_pre_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
    start_access(1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", mem_req); end
    rst = 1'b0; valid = 1'b0; memread = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_late_ack[%0d]: got done=%b req=%b expected 0/0", c, done, mem_req); end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_non_mem();
    for (int c = 0; c < 6; c++) begin
      valid = 1'b1; memread = 1'b0; memwrite = 1'b0;
      addr = ADDR_W'($urandom); wdata = DATA_W'($urandom);
      mem_ack = 1'b1; mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      checks++; if (stall !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL non_mem[%0d]: got stall=%b done=%b req=%b expected 0/0/0", c, stall, done, mem_req);
      end
      @(posedge clk); #1;
    end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL non_mem_state: got %0d expected %0d", dbg_state, IDLE); end
    valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    start_access(1'b1, 1'b0, 32'h6, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    exp_q.push_back({1'b1, 32'h0});
    run_until_done(2, 32'h12345678, 40);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL misalign_done_cycle: got %0d expected 1", done_cyc); end
    checks++; if (req_cnt !== 0) begin errors++; $display("FAIL misalign_req_cycles: got %0d expected 0", req_cnt); end
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL misalign_stall_cycles: got %0d expected 1", stall_cnt); end
`else
    exp_q.push_back({1'b0, 32'h12345678});
    run_until_done(2, 32'h12345678, 40);
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL misalign_done_cycle: got %0d expected 3", done_cyc); end
    checks++; if (seen_addr !== 32'h4) begin errors++; $display("FAIL misalign_mem_addr: got %h expected 4", seen_addr); end
`endif
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if ({seen_err, seen_rdata} !== exp) begin errors++; $display("FAIL misalign_result: got %h expected %h", {seen_err, seen_rdata}, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_store();
    test_ack_at_timeout();
    test_timeout();
    test_back_to_back();
    test_misaligned();
    test_reset_in_flight();
    test_non_mem();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store stage between execute and writeback of the single-cycle RISC-V core. It takes the ALU address, store data and memread/memwrite controls and runs a req/ack handshake with an external data memory of variable latency. While the access is in flight it stalls the core, then presents load data to writeback for one cycle. Fixed-latency `memory` stage becomes a memory-side slave of this block.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles in REQ waiting for ack before error (1..255)

- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- valid_i  input  1  instruction in execute is valid
- addr_i  input  ADDR_W  effective address (aluout)
- wdata_i  input  DATA_W  store data (rs2 data)
- memread_i  input  1  load request
- memwrite_i  input  1  store request
- stall_o  output  1  hold PC/regfile write; access pending
- done_o  output  1  one-cycle pulse, access finished
- err_o  output  1  one-cycle pulse with done_o, access failed
- rdata_o  output  DATA_W  load result to writeback
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write, 0 = read
- mem_addr_o  output  ADDR_W  word address to memory
- mem_wdata_o  output  DATA_W  store data to memory
- mem_ack_i  input  1  memory completion
- mem_rdata_i  input  DATA_W  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: start = valid_i & (memread_i | memwrite_i). On start, register addr, wdata, we (memwrite_i wins if both set) → REQ. stall_o = start (combinational).
- REQ: mem_req_o=1, mem_addr_o/mem_we_o/mem_wdata_o driven from registers, stable until ack. stall_o=1. Timeout counter increments each REQ cycle.
  - mem_ack_i=1 → capture mem_rdata_i (loads) or 0 (stores) into rdata_o → DONE.
  - counter reaches TIMEOUT with no ack → rdata_o=0, error flag → DONE.
- DONE: done_o=1, err_o=error flag, stall_o=0 (core advances at end of this cycle) → IDLE unconditionally; no retrigger from same instruction.
- rdata_o holds last captured value until next DONE; store completions write 0.
- mem_ack_i outside REQ ignored.
- rst=0 at any edge: state IDLE, counter/error/rdata_o cleared, mem_req_o drops at that edge; in-flight ack after reset ignored.

## Timing
- Reset values: stall_o=0 (until a start), done_o=0, err_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Start seen in cycle 0 → REQ from cycle 1. Ack in REQ cycle k (k≥1) → DONE in cycle k+1. Minimum: 3 cycles per memory instruction, stall_o high cycles 0..k.
- Ack in same cycle counter hits TIMEOUT: ack wins, no error.
- Timeout: DONE with err_o in cycle TIMEOUT+1.
- Non-memory instructions: stall_o=0, no state change, zero latency.

## Configuration
- LSU_ALIGN_CHECK_EN defined: start with addr_i[1:0]≠0 skips REQ, goes IDLE→DONE directly (stall_o=1 in cycle 0 only), done_o=1, err_o=1, rdata_o=0, no memory request issued.
- Undefined: no check; mem_addr_o low two bits forced to 0, access proceeds normally.

## Structure
- Package lsu_pkg: state enum (IDLE, REQ, DONE), default TIMEOUT constant, width defaults.
- Sub-module lsu_timeout_counter: 8-bit counter, clear/enable inputs, expired output at TIMEOUT.
- FSM, request registers and result register stay in load_store_unit.

## Test plan
- lw addr 0x10, ack after 2 REQ cycles with rdata 0xDEADBEEF → mem_we_o=0, mem_addr_o=0x10, rdata_o=0xDEADBEEF with done_o in cycle 3, stall_o high cycles 0–2.
- sw addr 0x8 data 5, immediate ack → mem_we_o=1, mem_wdata_o=5, done_o cycle 2, err_o=0, rdata_o=0.
- Load with ack never asserted, TIMEOUT=15 → done_o & err_o in cycle 16, rdata_o=0, mem_req_o low from cycle 16.
- rst=0 during REQ of a load → next cycle state IDLE, mem_req_o=0, later ack ignored, no done_o.
- add instruction (memread=memwrite=0) with stray mem_ack_i=1 → stall_o=0, no done_o, no mem_req_o.
- LSU_ALIGN_CHECK_EN, lw addr 0x6 → no mem_req_o, done_o & err_o cycle 1; without macro → mem_addr_o=0x4.
